// File: rtl/dcache_array_flush.sv
// dcache_array_flush: set-associative D-cache storage array with zero-latency
// lookup, victim selection (bit-PLRU or round-robin) and a flush engine that
// drains dirty blocks over a ready/valid handshake, optionally invalidating.
module dcache_array_flush #(
  parameter int SETS        = 8,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 4,
  parameter int TAG_BITS    = 8,
  parameter int REPL_MODE   = 0,
  localparam int IDX        = $clog2(SETS),
  localparam int ADDR_W     = TAG_BITS + IDX,
  localparam int BLOCK_BITS = 8 * BLOCK_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ren,
  input  logic                   wen,
  input  logic                   memWen,
  input  logic [BLOCK_BYTES-1:0] bytesAccess,
  input  logic [ADDR_W-1:0]      blockAddr,
  input  logic [BLOCK_BITS-1:0]  dataIn,
  output logic                   hit,
  output logic                   dirtyBit,
  output logic [BLOCK_BITS-1:0]  dataOut,
  output logic [TAG_BITS-1:0]    victimTag,
  input  logic                   flushReq,
  input  logic                   flushInv,
  output logic                   flushBusy,
  output logic                   flushValid,
  output logic [ADDR_W-1:0]      flushAddr,
  output logic [BLOCK_BITS-1:0]  flushData,
  input  logic                   flushReady,
  output logic                   flushDone
);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  // Storage: kept in flops because reset must clear tags and data too.
  logic [TAG_BITS-1:0]   tag_reg    [SETS][WAYS];
  logic [BLOCK_BITS-1:0] data_reg   [SETS][WAYS];
  logic [WAYS-1:0]       valid_reg  [SETS];
  logic [WAYS-1:0]       dirty_reg  [SETS];
  logic [WAYS-1:0]       status_reg [SETS];
  logic [WAY_W-1:0]      rr_reg     [SETS];

  state_t           state_reg, state_next;
  logic [IDX-1:0]   fset_reg, fset_next;
  logic [WAY_W-1:0] fway_reg, fway_next;
  logic             finv_reg, finv_next;

  logic [IDX-1:0]        idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  lookup_en;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit_any;
  logic [WAY_W-1:0]      hit_way, victim_way, sel_way, touch_way;
  logic [BLOCK_BITS-1:0] wr_merge;
  logic                  accept_en, do_ren, do_wen, do_fill, touch;
  logic [WAYS-1:0]       touch_onehot, status_new;
  logic                  flush_step, flush_ack, flush_last;

  assign idx       = blockAddr[IDX-1:0];
  assign tag       = blockAddr[ADDR_W-1:IDX];
  assign lookup_en = rst && (state_reg == IDLE) && (ren || wen || memWen);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
    assign hit_vec[gi] = valid_reg[idx][gi] && (tag_reg[idx][gi] == tag);
  end

  // Hit way: highest matching index wins should duplicates ever appear.
  always_comb begin
    hit_any = |hit_vec;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  // Victim: lowest invalid way first, then the replacement policy.
  always_comb begin
    logic             inv_found;
    logic [WAY_W-1:0] inv_way, plru_way;
    inv_found = 1'b0;
    inv_way   = '0;
    plru_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (!status_reg[idx][w]) plru_way = WAY_W'(w);
    end
    if (inv_found)           victim_way = inv_way;
    else if (REPL_MODE == 1) victim_way = rr_reg[idx];
    else                     victim_way = plru_way;
  end

  assign sel_way   = hit_any ? hit_way : victim_way;
  assign hit       = lookup_en && hit_any;
  assign dirtyBit  = lookup_en && dirty_reg[idx][sel_way];
  assign dataOut   = lookup_en ? data_reg[idx][sel_way] : '0;
  assign victimTag = (lookup_en && !hit_any) ? tag_reg[idx][victim_way] : '0;

  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_merge
    assign wr_merge[8*gi +: 8] = bytesAccess[gi] ? dataIn[8*gi +: 8]
                                                 : data_reg[idx][hit_way][8*gi +: 8];
  end

  // Strobes only act in IDLE and never in the cycle a flush is accepted.
  assign accept_en = (state_reg == IDLE) && !flushReq;
  assign do_ren    = accept_en && ren;
  assign do_wen    = accept_en && !ren && wen;
  assign do_fill   = accept_en && !ren && !wen && memWen;
  assign touch     = ((do_ren || do_wen) && hit_any) || do_fill;
  assign touch_way = hit_any ? hit_way : victim_way;

  // MRU bit update: set the touched bit, restart the epoch if all would be set.
  always_comb begin
    touch_onehot            = '0;
    touch_onehot[touch_way] = 1'b1;
    status_new              = status_reg[idx] | touch_onehot;
    if (&status_new) status_new = touch_onehot;
  end

  // Flush FSM register and cursor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      fset_reg  <= '0;
      fway_reg  <= '0;
      finv_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      fset_reg  <= fset_next;
      fway_reg  <= fway_next;
      finv_reg  <= finv_next;
    end
  end

  assign flush_last = (fset_reg == IDX'(SETS - 1)) && (fway_reg == WAY_W'(WAYS - 1));

  // Flush next-state: walk (set, way) with way innermost, stop on dirty blocks.
  always_comb begin
    state_next = state_reg;
    fset_next  = fset_reg;
    fway_next  = fway_reg;
    finv_next  = finv_reg;
    flush_step = 1'b0;
    flush_ack  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flushReq) begin
          finv_next  = flushInv;
          fset_next  = '0;
          fway_next  = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (valid_reg[fset_reg][fway_reg] && dirty_reg[fset_reg][fway_reg])
          state_next = EMIT;
        else
          flush_step = 1'b1;
      end
      EMIT: begin
        if (flushReady) begin
          flush_step = 1'b1;
          flush_ack  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_step) begin
      state_next = flush_last ? DONE : SCAN;
      if (fway_reg == WAY_W'(WAYS - 1)) begin
        fway_next = '0;
        fset_next = fset_reg + IDX'(1);
      end else begin
        fway_next = fway_reg + WAY_W'(1);
      end
    end
  end

  assign flushBusy  = (state_reg != IDLE);
  assign flushValid = (state_reg == EMIT);
  assign flushDone  = (state_reg == DONE);
  assign flushAddr  = flushValid ? {tag_reg[fset_reg][fway_reg], fset_reg} : '0;
  assign flushData  = flushValid ? data_reg[fset_reg][fway_reg] : '0;

  // Array update: CPU accesses in IDLE, flush clears while busy (never both).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s]  <= '0;
        dirty_reg[s]  <= '0;
        status_reg[s] <= '0;
        rr_reg[s]     <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_reg[s][w]  <= '0;
          data_reg[s][w] <= '0;
        end
      end
    end else begin
      if (do_wen && hit_any) begin
        data_reg[idx][hit_way]  <= wr_merge;
        dirty_reg[idx][hit_way] <= 1'b1;
      end
      if (do_fill) begin
        if (hit_any) begin
          data_reg[idx][hit_way]  <= dataIn;
          dirty_reg[idx][hit_way] <= 1'b0;
        end else begin
          valid_reg[idx][victim_way] <= 1'b1;
          dirty_reg[idx][victim_way] <= 1'b0;
          tag_reg[idx][victim_way]   <= tag;
          data_reg[idx][victim_way]  <= dataIn;
          if ((REPL_MODE == 1) && (&valid_reg[idx]))
            rr_reg[idx] <= (rr_reg[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[idx] + WAY_W'(1);
        end
      end
      if (touch) status_reg[idx] <= status_new;
      if (flush_ack) dirty_reg[fset_reg][fway_reg] <= 1'b0;
      if (flush_step && finv_reg) begin
        valid_reg[fset_reg][fway_reg] <= 1'b0;
        // The last way of a set being invalidated means the set is now empty.
        if (fway_reg == WAY_W'(WAYS - 1)) begin
          status_reg[fset_reg] <= '0;
          rr_reg[fset_reg]     <= '0;
        end
      end
    end
  end
endmodule
